i2c_master_ctrl: RTL and testbench



---
 rtl/i2c_master_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Byte-level open-drain I2C initiator: START / STOP / WRITE / READ over valid/ready.
// Optional responder clock stretching is enabled with `define I2C_MASTER_CLK_STRETCH_EN.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV    = 250,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rd_nack_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  busy_o,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_oe_o,
  output logic                  sda_oe_o
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH + 2);

  localparam logic [1:0] CmdStart = 2'b00;
  localparam logic [1:0] CmdStop  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StStop,
    StWrite,
    StRead,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            qtr_q, qtr_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  nack_q, nack_d;
  logic                  scl_q, scl_d;
  logic                  sda_q, sda_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  rsp_q, rsp_d;

  logic freeze;
  logic tick;
  logic last;
  logic load;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // Hold the quarter counter while the responder keeps SCL low after we released it.
  assign freeze = (qtr_q == 2'd1) && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign freeze     = 1'b0;
`endif

  assign tick = (cnt_q == CntW'(CLK_DIV - 1)) && !freeze;
  assign last = (qtr_q == 2'd3) &&
                ((state_q == StStart) || (state_q == StStop) || (bit_q == BitW'(DATA_WIDTH)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    nack_d  = nack_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rsp_d   = 1'b0;
    load    = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          cnt_d  = '0;
          qtr_d  = 2'd0;
          bit_d  = '0;
          tx_d   = wdata_i;
          nack_d = rd_nack_i;
          err_d  = 1'b0;
          if ((cmd_i != CmdStart) && !busy_q) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            load = 1'b1;
            unique case (cmd_i)
              CmdStart: state_d = StStart;
              CmdStop:  state_d = StStop;
              CmdWrite: state_d = StWrite;
              default:  state_d = StRead;
            endcase
            if (cmd_i == CmdStart) busy_d = 1'b1;
          end
        end
      end
      StResp: begin
        rsp_d   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        if (!freeze) cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          if (qtr_q == 2'd2) begin
            if (state_q == StRead && bit_q < BitW'(DATA_WIDTH)) begin
              rdata_d = {rdata_q[DATA_WIDTH-2:0], sda_i};
            end
            if (state_q == StWrite && bit_q == BitW'(DATA_WIDTH)) ack_d = ~sda_i;
          end
          if (last) begin
            state_d = StResp;
            if (state_q == StStop) busy_d = 1'b0;
          end else begin
            load = 1'b1;
            if (qtr_q == 2'd3) begin
              qtr_d = 2'd0;
              bit_d = bit_q + 1'b1;
              tx_d  = tx_q << 1;
            end else begin
              qtr_d = qtr_q + 2'd1;
            end
          end
        end
      end
    endcase

    // Line levels for the quarter being entered; lines only move on accept or tick.
    if (load) begin
      case (state_d)
        StStart: begin
          unique case (qtr_d)
            2'd0:    begin scl_d = scl_q; sda_d = 1'b0; end
            2'd1:    begin scl_d = 1'b0;  sda_d = 1'b0; end
            2'd2:    begin scl_d = 1'b0;  sda_d = 1'b1; end
            default: begin scl_d = 1'b1;  sda_d = 1'b1; end
          endcase
        end
        StStop: begin
          unique case (qtr_d)
            2'd0:    begin scl_d = 1'b1; sda_d = 1'b1; end
            2'd1:    begin scl_d = 1'b0; sda_d = 1'b1; end
            default: begin scl_d = 1'b0; sda_d = 1'b0; end
          endcase
        end
        default: begin
          scl_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
          if (bit_d == BitW'(DATA_WIDTH)) begin
            sda_d = (state_d == StRead) ? ~nack_d : 1'b0;
          end else begin
            sda_d = (state_d == StWrite) ? ~tx_d[DATA_WIDTH-1] : 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= '0;
      tx_q    <= '0;
      nack_q  <= 1'b0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      nack_q  <= nack_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rsp_q   <= rsp_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign rsp_valid_o = rsp_q;
  assign rdata_o     = rdata_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign scl_oe_o    = scl_q;
  assign sda_oe_o    = sda_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with CLK_DIV=4 and a small responder model on the bus.
module tb_i2c_master_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic       rd_nack = 1'b0;
  logic       cmd_ready, rsp_valid, ack, err, busy, scl_oe, sda_oe;
  logic [7:0] rdata;
  logic       scl_line, sda_line;
  logic       hold = 1'b0;
  logic       resp_low;
  logic [7:0] rsh;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int sda_rise_cyc = 0;
  int scl_rise_cyc = 0;
  int sda_fall_cyc = 0;
  int sda_fall_scl_rel = 0;
  int oe_rises = 0;
  int scl_falls = 0;
  int scl_rises = 0;
  int fall_base = 0;
  int bitn;
  int mode = 0;
  logic [7:0] rbyte = 8'h00;
  logic [8:0] mon_bits = 9'h0;
  int lat;
  logic [7:0] r_rdata;
  logic r_ack, r_err;

  i2c_master_ctrl #(.CLK_DIV(D), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_i(cmd),
    .wdata_i(wdata), .rd_nack_i(rd_nack), .rsp_valid_o(rsp_valid), .rdata_o(rdata),
    .ack_o(ack), .err_o(err), .busy_o(busy), .scl_i(scl_line), .sda_i(sda_line),
    .scl_oe_o(scl_oe), .sda_oe_o(sda_oe)
  );

  always #5 clk = ~clk;

  assign scl_line = ~scl_oe & ~hold;
  assign sda_line = ~sda_oe & ~resp_low;
  assign bitn     = scl_falls - fall_base;

  // Responder: mode 1 ACKs the 9th bit, mode 2 returns rbyte MSB first.
  always_comb begin
    rsh      = rbyte << bitn;
    resp_low = 1'b0;
    if (mode == 1) resp_low = (bitn == 8);
    else if (mode == 2) resp_low = (bitn < 8) && !rsh[7];
  end

  always @(posedge clk) cyc++;
  always @(posedge sda_oe) begin sda_rise_cyc = cyc; oe_rises++; end
  always @(posedge scl_oe) begin scl_rise_cyc = cyc; oe_rises++; scl_falls++; end
  always @(negedge sda_oe) begin sda_fall_cyc = cyc; sda_fall_scl_rel = int'(!scl_oe); end
  always @(negedge scl_oe) begin
    #1;
    mon_bits = {mon_bits[7:0], sda_line};
    scl_rises++;
  end

  task automatic issue(input logic [1:0] c, input logic [7:0] wd, input logic nk,
                       output int l);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; wdata = wd; rd_nack = nk;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    l = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin l = i; break; end
    end
    r_rdata = rdata; r_ack = ack; r_err = err;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (scl_oe !== 1'b0) begin failures++; $display("FAIL reset_scl_oe got=%b exp=0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%b exp=0", rsp_valid); end
    checks++; if ({busy, ack, err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, ack, err}); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_error_idle();
    int r0;
    r0 = oe_rises;
    issue(2'b10, 8'h55, 1'b0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL err_latency got=%0d exp=1", lat); end
    checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", r_err); end
    checks++; if (oe_rises !== r0) begin failures++; $display("FAIL err_bus_activity got=%0d exp=%0d", oe_rises, r0); end
    checks++; if ({scl_oe, sda_oe} !== 2'b00) begin failures++; $display("FAIL err_lines got=%b exp=00", {scl_oe, sda_oe}); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL err_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_start();
    issue(2'b00, 8'h00, 1'b0, lat);
    checks++; if (lat !== 4 * D + 1) begin failures++; $display("FAIL start_latency got=%0d exp=%0d", lat, 4 * D + 1); end
    checks++; if (sda_rise_cyc - acc_cyc !== 2 * D) begin failures++; $display("FAIL start_sda_time got=%0d exp=%0d", sda_rise_cyc - acc_cyc, 2 * D); end
    checks++; if (scl_rise_cyc - sda_rise_cyc !== D) begin failures++; $display("FAIL start_scl_after_sda got=%0d exp=%0d", scl_rise_cyc - sda_rise_cyc, D); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy); end
    checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL start_err got=%b exp=0", r_err); end
  endtask

  task automatic test_write(input logic [7:0] wd, input int m, input logic exp_ack);
    int rb;
    mode = m; fall_base = scl_falls; rb = scl_rises;
    issue(2'b10, wd, 1'b0, lat);
    mode = 0;
    checks++; if (lat !== 36 * D + 1) begin failures++; $display("FAIL write_latency got=%0d exp=%0d", lat, 36 * D + 1); end
    checks++; if (mon_bits[8:1] !== wd) begin failures++; $display("FAIL write_bits got=%h exp=%h", mon_bits[8:1], wd); end
    checks++; if (scl_rises - rb !== 9) begin failures++; $display("FAIL write_clocks got=%0d exp=9", scl_rises - rb); end
    checks++; if (r_ack !== exp_ack) begin failures++; $display("FAIL write_ack got=%b exp=%b", r_ack, exp_ack); end
    checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL write_err got=%b exp=0", r_err); end
  endtask

  task automatic test_read();
    mode = 2; rbyte = 8'h5A; fall_base = scl_falls;
    issue(2'b11, 8'h00, 1'b1, lat);
    mode = 0;
    checks++; if (lat !== 36 * D + 1) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", lat, 36 * D + 1); end
    checks++; if (r_rdata !== 8'h5A) begin failures++; $display("FAIL read_rdata got=%h exp=5a", r_rdata); end
    checks++; if (mon_bits[0] !== 1'b1) begin failures++; $display("FAIL read_nack_bit got=%b exp=1", mon_bits[0]); end
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL read_sda_released got=%b exp=0", sda_oe); end
  endtask

  task automatic test_stop();
    issue(2'b01, 8'h00, 1'b0, lat);
    checks++; if (lat !== 4 * D + 1) begin failures++; $display("FAIL stop_latency got=%0d exp=%0d", lat, 4 * D + 1); end
    checks++; if (sda_fall_cyc - acc_cyc !== 2 * D) begin failures++; $display("FAIL stop_sda_time got=%0d exp=%0d", sda_fall_cyc - acc_cyc, 2 * D); end
    checks++; if (sda_fall_scl_rel !== 1) begin failures++; $display("FAIL stop_scl_high got=%0d exp=1", sda_fall_scl_rel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", busy); end
    checks++; if ({scl_oe, sda_oe} !== 2'b00) begin failures++; $display("FAIL stop_lines got=%b exp=00", {scl_oe, sda_oe}); end
    checks++; if (rdata !== 8'h5A) begin failures++; $display("FAIL stop_rdata_hold got=%h exp=5a", rdata); end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(2'b00, 8'h00, 1'b0, lat);
    checks++; if (lat !== 4 * D + 1) begin failures++; $display("FAIL rmid_start_latency got=%0d exp=%0d", lat, 4 * D + 1); end
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 2'b10; wdata = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (50) @(posedge clk);
    #3;
    checks++; if ({scl_oe, sda_oe} !== 2'b11) begin failures++; $display("FAIL rmid_pre_lines got=%b exp=11", {scl_oe, sda_oe}); end
    rst = 1'b1;
    #1;
    checks++; if ({scl_oe, sda_oe} !== 2'b00) begin failures++; $display("FAIL rmid_lines got=%b exp=00", {scl_oe, sda_oe}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rmid_no_rsp got=%0d exp=0", seen); end
    checks++; if ({cmd_ready, busy} !== 2'b10) begin failures++; $display("FAIL rmid_idle got=%b exp=10", {cmd_ready, busy}); end
  endtask

`ifdef I2C_MASTER_CLK_STRETCH_EN
  task automatic test_stretch();
    issue(2'b00, 8'h00, 1'b0, lat);
    fall_base = scl_falls;
    fork
      issue(2'b10, 8'hA4, 1'b0, lat);
      begin
        int k;
        k = 0;
        while (bitn != 3 && k < 3000) begin @(posedge clk); k++; end
        if (bitn == 3) begin
          @(negedge scl_oe);
          hold = 1'b1;
          repeat (20) @(posedge clk);
          #1 hold = 1'b0;
        end
      end
    join
    checks++; if (lat !== 36 * D + 1 + 20) begin failures++; $display("FAIL stretch_latency got=%0d exp=%0d", lat, 36 * D + 21); end
    issue(2'b01, 8'h00, 1'b0, lat);
  endtask
`endif

  initial begin
    test_reset();
    test_error_idle();
    test_start();
    test_write(8'hA4, 1, 1'b1);
    test_write(8'h3C, 0, 1'b0);
    test_read();
    test_stop();
    test_reset_mid();
`ifdef I2C_MASTER_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
